// File: rtl/interp2_pkg.sv
// Shared types and constants for the 2x linear-interpolation upsampler.
// Rounding of the midpoint is selected with the INTERP2_ROUND_EN macro (see interp2_avg).
package interp2_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MID   = 2'd1,
        CUR   = 2'd2
    } state_t;

    localparam logic PH_MID = 1'b0;
    localparam logic PH_CUR = 1'b1;

endpackage : interp2_pkg

// File: rtl/interp2_avg.sv
// Combinational midpoint of two unsigned samples using a WIDTH+1-bit sum.
// Macro INTERP2_ROUND_EN: defined -> round half up, undefined -> floor.
module interp2_avg
    import interp2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] sum;

`ifdef INTERP2_ROUND_EN
    // Max (2^W-1)*2+1 still fits in W+1 bits, so the carry is never lost.
    assign sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(1);
`else
    assign sum = SUM_W'(a) + SUM_W'(b);
`endif

    assign y = sum[SUM_W-1:1];

endmodule : interp2_avg

// File: rtl/interp2_upsampler.sv
// 2x linear-interpolation upsampler: each input x[n] emits mid(x[n-1], x[n]) then x[n].
// Midpoint rounding selected by macro INTERP2_ROUND_EN (default floor).
module interp2_upsampler
    import interp2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_phase
);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] avg_a;
    logic [WIDTH-1:0] mid;
    logic             in_xfer;
    logic             out_xfer;

    // Held low during reset so nothing is accepted while the block is cleared.
    assign in_ready = RST_N & ((state == EMPTY) | ((state == CUR) & out_ready));
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Back-to-back accept in CUR interpolates against the sample that is leaving now.
    assign avg_a = (state == CUR) ? cur : prev;

    interp2_avg #(
        .WIDTH (WIDTH)
    ) u_avg (
        .a (avg_a),
        .b (in_data),
        .y (mid)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= EMPTY;
            prev      <= '0;
            cur       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_phase <= PH_MID;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= MID;
                        cur       <= in_data;
                        out_valid <= 1'b1;
                        out_data  <= mid;
                        out_phase <= PH_MID;
                    end
                end
                MID: begin
                    if (out_xfer) begin
                        state     <= CUR;
                        out_data  <= cur;
                        out_phase <= PH_CUR;
                    end
                end
                CUR: begin
                    if (out_xfer) begin
                        prev <= cur;
                        if (in_xfer) begin
                            state     <= MID;
                            cur       <= in_data;
                            out_data  <= mid;
                            out_phase <= PH_MID;
                        end else begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : interp2_upsampler

// File: tb/tb_interp2_upsampler.sv
// Directed table-driven bench for interp2_upsampler; honours INTERP2_ROUND_EN like the RTL.
module tb_interp2_upsampler;

    localparam int unsigned WIDTH = 8;

`ifdef INTERP2_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             CLK;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_phase;

    interp2_upsampler #(
        .WIDTH (WIDTH)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        bit         e_ir;
        bit         e_ov;
        logic [7:0] e_od;
        bit         e_ph;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic add(input bit rst, input bit iv, input int d, input bit ordy,
                       input bit e_ir, input bit e_ov, input int e_od, input bit e_ph);
        vec_t v;
        v.rst  = rst;
        v.iv   = iv;
        v.d    = 8'(d);
        v.ordy = ordy;
        v.e_ir = e_ir;
        v.e_ov = e_ov;
        v.e_od = 8'(e_od);
        v.e_ph = e_ph;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit e_ir, input bit e_ov,
                              input int e_od, input bit e_ph);
        n_vec++;
        chk({tag, ".in_ready"}, int'(in_ready), int'(e_ir));
        chk({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
        if (e_ov) begin
            chk({tag, ".out_data"}, int'(out_data), e_od);
            chk({tag, ".out_phase"}, int'(out_phase), int'(e_ph));
        end
    endtask

    // Called at a negedge; leaves the bench at a later negedge with reset released.
    task automatic do_reset();
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_outs("rst", 1'b0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    int m_ff;
    int m_03;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        RST_N     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_ff      = ROUND ? 128 : 127;
        m_03      = ROUND ? 2 : 1;

        #1;
        n_vec++;
        chk("reset.in_ready", int'(in_ready), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.out_data", int'(out_data), 0);
        chk("reset.out_phase", int'(out_phase), 0);

        // rst iv  d    ordy ir ov  od   ph
        // Single sample 100
        add(1, 1, 100, 1, 1, 0, 0,   0);
        add(0, 0, 0,   1, 0, 1, 50,  0);
        add(0, 0, 0,   1, 1, 1, 100, 1);
        add(0, 0, 0,   1, 1, 0, 0,   0);
        // Stream 100,200,50 back-to-back
        add(1, 1, 100, 1, 1, 0, 0,   0);
        add(0, 1, 200, 1, 0, 1, 50,  0);
        add(0, 1, 200, 1, 1, 1, 100, 1);
        add(0, 1, 50,  1, 0, 1, 150, 0);
        add(0, 1, 50,  1, 1, 1, 200, 1);
        add(0, 0, 0,   1, 0, 1, 125, 0);
        add(0, 0, 0,   1, 1, 1, 50,  1);
        add(0, 0, 0,   1, 1, 0, 0,   0);
        // Stall 4 cycles in MID, then stall once in CUR
        add(1, 1, 100, 0, 1, 0, 0,   0);
        add(0, 1, 7,   0, 0, 1, 50,  0);
        add(0, 1, 7,   0, 0, 1, 50,  0);
        add(0, 1, 7,   0, 0, 1, 50,  0);
        add(0, 1, 7,   0, 0, 1, 50,  0);
        add(0, 0, 0,   1, 0, 1, 50,  0);
        add(0, 1, 9,   0, 0, 1, 100, 1);
        add(0, 0, 0,   1, 1, 1, 100, 1);
        add(0, 0, 0,   0, 1, 0, 0,   0);
        // Full-scale 255,255: no wrap
        add(1, 1, 255, 1, 1, 0, 0,    0);
        add(0, 0, 0,   1, 0, 1, m_ff, 0);
        add(0, 1, 255, 1, 1, 1, 255,  1);
        add(0, 0, 0,   1, 0, 1, 255,  0);
        add(0, 0, 0,   1, 1, 1, 255,  1);
        add(0, 0, 0,   1, 1, 0, 0,    0);
        // Odd sum 0 then 3
        add(1, 1, 0,   1, 1, 0, 0,    0);
        add(0, 0, 0,   1, 0, 1, 0,    0);
        add(0, 1, 3,   1, 1, 1, 0,    1);
        add(0, 0, 0,   1, 0, 1, m_03, 0);
        add(0, 0, 0,   1, 1, 1, 3,    1);
        add(0, 0, 0,   1, 1, 0, 0,    0);

        @(negedge CLK);
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                       int'(vecs[i].e_od), vecs[i].e_ph);
            @(negedge CLK);
        end

        // Async reset while x[n] is pending in CUR; prev must be cleared afterwards
        do_reset();
        in_valid  = 1'b1;
        in_data   = 8'd10;
        out_ready = 1'b1;
        #1;
        check_outs("ar.accept", 1'b1, 1'b0, 0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        check_outs("ar.mid", 1'b0, 1'b1, 5, 1'b0);
        @(negedge CLK);
        out_ready = 1'b0;
        #1;
        check_outs("ar.cur", 1'b0, 1'b1, 10, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check_outs("ar.async", 1'b0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        RST_N     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd40;
        out_ready = 1'b1;
        #1;
        check_outs("ar.relaccept", 1'b1, 1'b0, 0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        check_outs("ar.mid40", 1'b0, 1'b1, 20, 1'b0);
        @(negedge CLK);
        #1;
        check_outs("ar.cur40", 1'b1, 1'b1, 40, 1'b1);
        @(negedge CLK);
        #1;
        check_outs("ar.idle", 1'b1, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_interp2_upsampler
